// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline-side signals seen by the Y86-64 sequencing controller.
// master = the controller (drives PC and stage controls), slave = the pipeline datapath.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       f_icode;
    logic [63:0]      f_valC;
    logic [63:0]      f_valP;
    logic [1:0]       f_stat;
    logic [3:0]       D_icode;
    logic [3:0]       E_icode;
    logic [3:0]       M_icode;
    logic [3:0]       W_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic             M_Cnd;
    logic [63:0]      M_valA;
    logic [63:0]      W_valM;
    logic [1:0]       m_stat;
    logic [1:0]       W_stat;
    logic [63:0]      f_pc;
    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic             set_cc;
    logic             halted;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic [CNT_W-1:0] bub_cnt;

    modport master (
        input  f_icode, f_valC, f_valP, f_stat,
        input  D_icode, E_icode, M_icode, W_icode,
        input  d_srcA, d_srcB, E_dstM, e_Cnd, M_Cnd,
        input  M_valA, W_valM, m_stat, W_stat,
        output f_pc, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        output set_cc, halted, cyc_cnt, ret_cnt, bub_cnt
    );

    modport slave (
        output f_icode, f_valC, f_valP, f_stat,
        output D_icode, E_icode, M_icode, W_icode,
        output d_srcA, d_srcB, E_dstM, e_Cnd, M_Cnd,
        output M_valA, W_valM, m_stat, W_stat,
        input  f_pc, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        input  set_cc, halted, cyc_cnt, ret_cnt, bub_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline sequencer: predicted PC, fetch PC select, stall/bubble controls, run/drain/halt FSM.
// Optional performance counters are built only when PIPE_PERF_EN is defined.
module pipe_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic        clock,
    input  logic        reset,
    pipe_ctrl_if.master bus
);
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [63:0] pred_pc_reg, pred_pc_next;
    logic        pred_load;
    logic        lu, rt, mp;
    logic        f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall;
    logic        halted_c, set_cc_c;
    logic [63:0] f_pc_c;
    logic [3:0]  stage_icode [3];
    logic [2:0]  in_ret;
    logic        unused_e_cnd;

    genvar gi;

    assign unused_e_cnd = bus.e_Cnd;

    assign stage_icode[0] = bus.D_icode;
    assign stage_icode[1] = bus.E_icode;
    assign stage_icode[2] = bus.M_icode;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_ret
            assign in_ret[gi] = (stage_icode[gi] == I_RET);
        end
    endgenerate

    assign rt = |in_ret;
    assign lu = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
                (bus.E_dstM != R_NONE) &&
                ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    assign mp = (bus.M_icode == I_JXX) && !bus.M_Cnd;

    assign pred_pc_next = ((bus.f_icode == I_JXX) || (bus.f_icode == I_CALL)) ? bus.f_valC
                                                                               : bus.f_valP;

    always_comb begin
        if (mp) begin
            f_pc_c = bus.M_valA;
        end else if (bus.W_icode == I_RET) begin
            f_pc_c = bus.W_valM;
        end else begin
            f_pc_c = pred_pc_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        f_stall    = lu | rt;
        d_stall    = lu;
        d_bubble   = mp | (rt & !lu);
        e_bubble   = mp | lu;
        m_bubble   = 1'b0;
        w_stall    = 1'b0;
        halted_c   = 1'b0;
        pred_load  = !(lu | rt);
        case (state_reg)
            ST_RUN: begin
                if ((bus.f_stat != 2'b00) && !(mp | rt) && !(lu | rt)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                f_stall = 1'b1;
                // A mispredict squashes the faulting fetch, so fetch resumes at the corrected PC.
                pred_load = mp && !(lu | rt);
                if (mp) begin
                    state_next = ST_RUN;
                end
            end
            ST_HALT: begin
                f_stall   = 1'b1;
                d_stall   = 1'b0;
                d_bubble  = 1'b1;
                e_bubble  = 1'b1;
                m_bubble  = 1'b1;
                w_stall   = 1'b1;
                halted_c  = 1'b1;
                pred_load = 1'b0;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
        if ((state_reg != ST_HALT) && (bus.W_stat != 2'b00)) begin
            state_next = ST_HALT;
        end
        set_cc_c = !((bus.m_stat != 2'b00) || (bus.W_stat != 2'b00) || (state_reg == ST_HALT));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_RUN;
            pred_pc_reg <= RESET_PC;
        end else begin
            state_reg <= state_next;
            if (pred_load) begin
                pred_pc_reg <= pred_pc_next;
            end
        end
    end

    // Outputs are pinned to their idle values while reset is held, whatever the pipeline presents.
    always_comb begin
        bus.f_pc     = RESET_PC;
        bus.F_stall  = 1'b0;
        bus.D_stall  = 1'b0;
        bus.D_bubble = 1'b0;
        bus.E_bubble = 1'b0;
        bus.M_bubble = 1'b0;
        bus.W_stall  = 1'b0;
        bus.set_cc   = 1'b1;
        bus.halted   = 1'b0;
        if (!reset) begin
            bus.f_pc     = f_pc_c;
            bus.F_stall  = f_stall;
            bus.D_stall  = d_stall;
            bus.D_bubble = d_bubble;
            bus.E_bubble = e_bubble;
            bus.M_bubble = m_bubble;
            bus.W_stall  = w_stall;
            bus.set_cc   = set_cc_c;
            bus.halted   = halted_c;
        end
    end

`ifdef PIPE_PERF_EN
    logic [2:0] cnt_inc;

    assign cnt_inc[0] = (state_reg != ST_HALT);
    assign cnt_inc[1] = (bus.W_stat == 2'b00) && (bus.W_icode != I_HALT) &&
                        (bus.W_icode != I_NOP) && !w_stall;
    assign cnt_inc[2] = d_bubble | e_bubble;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi]) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign bus.cyc_cnt = g_cnt[0].cnt_reg;
    assign bus.ret_cnt = g_cnt[1].cnt_reg;
    assign bus.bub_cnt = g_cnt[2].cnt_reg;
`else
    assign bus.cyc_cnt = '0;
    assign bus.ret_cnt = '0;
    assign bus.bub_cnt = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Sequencing controller for the five-stage Y86-64 pipeline. It holds the predicted-PC register, selects the fetch PC and computes the per-stage stall and bubble controls for load/use hazards, `ret` processing and mispredicted branches. It also runs a run/drain/halt state machine driven by the status codes from fetch and writeback. It sits beside the pipeline registers and drives the `PC` input of the fetch stage.

## Interface
Parameters:
- `RESET_PC`, 64'h0: value loaded into the predicted PC on reset.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high.
- `f_icode`  in  4: icode decoded by fetch this cycle.
- `f_valC`, `f_valP`  in  64 each: constant word and fall-through PC from fetch.
- `f_stat`  in  2: fetch status. 00 AOK, 01 HLT, 10 ADR, 11 INS.
- `D_icode`, `E_icode`, `M_icode`, `W_icode`  in  4 each: icodes held in the D/E/M/W pipeline registers.
- `d_srcA`, `d_srcB`, `E_dstM`  in  4 each: decode source registers and execute load destination. 4'hF means none.
- `e_Cnd`  in  1: unused, reserved.
- `M_Cnd`  in  1: condition outcome latched for the jump in M.
- `M_valA`  in  64: fall-through PC carried by a jump in M.
- `W_valM`  in  64: return address from a `ret` in W.
- `m_stat`, `W_stat`  in  2 each: memory-stage and writeback status.
- `f_pc`  out  64: PC presented to fetch.
- `F_stall`, `D_stall`, `D_bubble`, `E_bubble`, `M_bubble`, `W_stall`  out  1 each: pipeline register controls.
- `set_cc`  out  1: condition-code write enable for execute.
- `halted`  out  1: high in HALT state.
- `cyc_cnt`, `ret_cnt`, `bub_cnt`  out  CNT_W each: performance counters.

## Operation
Hazard terms, all combinational:
- `lu` (load/use) = E_icode ∈ {5 mrmovq, B popq} and E_dstM ≠ F and E_dstM ∈ {d_srcA, d_srcB}.
- `rt` (ret in flight) = 9 ∈ {D_icode, E_icode, M_icode}.
- `mp` (mispredict) = M_icode = 7 and !M_Cnd.

PC select, in priority order:
- `mp` → M_valA.
- else W_icode = 9 → W_valM.
- else predPC.

predPC register:
- Loads on every cycle with F_stall = 0.
- Next value is f_valC if f_icode ∈ {7, 8}, else f_valP.

FSM states:
- RUN (entered from reset).
  - F_stall = lu | rt.
  - D_stall = lu.
  - D_bubble = mp | (rt & !lu).
  - E_bubble = mp | lu.
  - M_bubble = 0, W_stall = 0.
- DRAIN: the bad-status instruction is in flight and no further fetch is allowed.
  - F_stall forced to 1.
  - All other controls as in RUN.
- HALT.
  - F_stall = D_bubble = E_bubble = M_bubble = W_stall = 1.
  - D_stall = 0, halted = 1.

FSM transitions:
- RUN → DRAIN when f_stat ≠ 00 and !(mp | rt) and !F_stall.
- DRAIN → RUN when mp. The faulting fetch was on the wrong path; predPC is reloaded from the PC-select path.
- RUN or DRAIN → HALT when W_stat ≠ 00. This takes priority over the other transitions.
- HALT is left only by reset.

set_cc:
- set_cc = 0 when m_stat ≠ 00, W_stat ≠ 00, or state = HALT.
- Otherwise set_cc = 1.

Boundary cases:
- `lu` and `rt` together: load/use wins. D is stalled, not bubbled, and E is bubbled.
- `mp` together with `lu`: both D_bubble and E_bubble are 1.
- Reset in any state: all registers return to their reset values on the next edge.

## Timing
- Reset values: state = RUN, predPC = RESET_PC, all counters = 0.
- Reset values of outputs while reset is held: f_pc = RESET_PC, all stall/bubble outputs = 0, halted = 0, set_cc = 1.
- All outputs are combinational from registered state plus the inputs. There is zero-cycle latency from inputs to controls.
- predPC and state update on the rising edge of `clock`.
- A load/use hazard costs one bubble.
- A `ret` costs three bubbles. The return target appears on f_pc in the same cycle the `ret` is in W.
- A mispredict costs two bubbles. M_valA appears on f_pc in the same cycle the jump is in M.
- `halted` rises in the cycle after W_stat first becomes non-zero.

## Configuration
- `PIPE_PERF_EN` defined:
  - cyc_cnt increments every cycle in which state ≠ HALT.
  - ret_cnt increments when W_stat = 00, W_icode ∉ {0, 1} and !W_stall.
  - bub_cnt increments when D_bubble or E_bubble is asserted.
  - All three counters wrap modulo 2^CNT_W.
- `PIPE_PERF_EN` undefined: the three counter ports are tied to 0 and no counter flops are inferred.

## Test plan
- Reset with RESET_PC = 64'h100, released for one cycle with f_icode = 3, f_valP = 64'h10A → f_pc = 64'h100 at reset; f_pc = 64'h10A after the first edge.
- Load/use: E_icode = 5, E_dstM = 2, d_srcA = 2 → F_stall = D_stall = E_bubble = 1, D_bubble = 0; predPC holds its value.
- Mispredict: M_icode = 7, M_Cnd = 0, M_valA = 64'h40 → f_pc = 64'h40, D_bubble = E_bubble = 1.
- `ret` sequence: D_icode = 9 for one cycle, then the `ret` advances → D_bubble held for 3 cycles; with W_icode = 9 and W_valM = 64'h88 → f_pc = 64'h88.
- Halt: f_stat = 01 → state DRAIN and F_stall = 1; three cycles later W_stat = 01 → next cycle halted = 1, W_stall = 1, set_cc = 0; reset returns state to RUN.
- With `PIPE_PERF_EN`: 10 cycles after reset containing 2 bubbles → cyc_cnt = 10, bub_cnt = 2.
